// File: rtl/cpu_controller.sv
// cpu_controller: multicycle fetch/decode/execute FSM for the 16-bit CPU with
// configurable memory read latency, run/step gating, halt and retired-instruction count.
module cpu_controller #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    input  logic             run,
    input  logic             step,
    output logic [1:0]       nsel,
    output logic [1:0]       vsel,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic             loadir,
    output logic             loadpc,
    output logic             reset_pc,
    output logic             msel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [4:0] {
        RST, IDLE, IF1, IF2, UPC, DEC, WRI, GETA, GETB, EXE, WRC,
        ADR, MRD, WRM, STO, DONE, HALT
    } state_t;

    state_t state, next;
    logic [CW-1:0] cnt;
    logic last, is_alu, is_ldr, is_str, is_cmp;

    assign last   = cnt == CW'(MEM_LATENCY - 1);
    assign is_alu = opcode == 3'b101;
    assign is_ldr = opcode == 3'b011;
    assign is_str = opcode == 3'b100;
    assign is_cmp = is_alu && op == 2'b01;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= RST;
            cnt    <= '0;
            icount <= '0;
        end else begin
            state  <= next;
            cnt    <= ((state == IF1 || state == MRD) && !last) ? cnt + CW'(1) : '0;
            if (state == DONE) icount <= icount + CNT_W'(1);
        end
    end

    always_comb begin
        next = state;
        case (state)
            RST:  next = IDLE;
            IDLE: next = (run || step) ? IF1 : IDLE;
            IF1:  next = last ? IF2 : IF1;
            IF2:  next = UPC;
            UPC:  next = DEC;
            DEC:  case ({opcode, op})
                      5'b110_10: next = WRI;
                      5'b110_00: next = GETB;
                      5'b011_00,
                      5'b100_00: next = GETA;
                      default:   next = is_alu ? GETA : (opcode == 3'b111) ? HALT : DONE;
                  endcase
            WRI:  next = DONE;
            GETA: next = is_alu ? GETB : ADR;
            GETB: next = is_str ? STO : EXE;
            EXE:  next = is_cmp ? DONE : WRC;
            WRC:  next = DONE;
            ADR:  next = is_ldr ? MRD : GETB;
            MRD:  next = last ? WRM : MRD;
            WRM:  next = DONE;
            STO:  next = DONE;
            DONE: next = IDLE;
            HALT: next = HALT;
            default: next = RST;
        endcase
    end

    always_comb begin
        {nsel, vsel} = 4'b0000;
        {write, loada, loadb, loadc, loads, asel, bsel} = 7'b0;
        {loadir, loadpc, reset_pc, msel, mem_read, mem_write, halted} = 7'b0;
        case (state)
            RST:  {reset_pc, loadpc} = 2'b11;
            IF1:  mem_read = 1'b1;
            IF2:  {mem_read, loadir} = 2'b11;
            UPC:  loadpc = 1'b1;
            WRI:  {vsel, write} = {2'b01, 1'b1};
            GETA: loada = 1'b1;
            GETB: {nsel, loadb} = {is_str ? 2'b01 : 2'b10, 1'b1};
            EXE:  {asel, loadc, loads} = {opcode == 3'b110, !is_cmp, is_cmp};
            WRC:  {nsel, vsel, write} = {2'b01, 2'b11, 1'b1};
            ADR:  {bsel, loadc} = 2'b11;
            MRD:  {msel, mem_read} = 2'b11;
            WRM:  {nsel, msel, mem_read, write} = {2'b01, 3'b111};
            STO:  {msel, mem_write} = 2'b11;
            HALT: halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed checks of fetch/execute sequencing, step gating,
// halt, latency and counter wrap on two controller configurations.
module tb_cpu_controller;
    logic clk = 0, reset = 0, run = 0, step = 0;
    logic [2:0] opcode = 3'b110;
    logic [1:0] op = 2'b10;
    logic [1:0] nsel, vsel, nsel3, vsel3;
    logic write, loada, loadb, loadc, loads, asel, bsel, loadir, loadpc, reset_pc;
    logic msel, mem_read, mem_write, halted;
    logic write3, loada3, loadb3, loadc3, loads3, asel3, bsel3, loadir3, loadpc3, reset_pc3;
    logic msel3, mem_read3, mem_write3, halted3;
    logic [15:0] icount;
    logic [1:0] icount3;
    int n_cmp = 0, n_bad = 0;
    int c_a, c_b, c_c, c_d, c_e;

    always #5 clk = ~clk;

    cpu_controller #(.MEM_LATENCY(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .run(run), .step(step),
        .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .loadir(loadir),
        .loadpc(loadpc), .reset_pc(reset_pc), .msel(msel), .mem_read(mem_read),
        .mem_write(mem_write), .halted(halted), .icount(icount));

    cpu_controller #(.MEM_LATENCY(3), .CNT_W(2)) dut3 (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .run(run), .step(step),
        .nsel(nsel3), .vsel(vsel3), .write(write3), .loada(loada3), .loadb(loadb3),
        .loadc(loadc3), .loads(loads3), .asel(asel3), .bsel(bsel3), .loadir(loadir3),
        .loadpc(loadpc3), .reset_pc(reset_pc3), .msel(msel3), .mem_read(mem_read3),
        .mem_write(mem_write3), .halted(halted3), .icount(icount3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset and first MOVI R0,#7 with L=1
        tick;
        chk("rst_state", {reset_pc, loadpc, halted}, 3'b110);
        chk("rst_icount", icount, 0);
        reset = 1; run = 1;
        tick; chk("idle_c1", {mem_read, loadir}, 2'b00);
        tick; chk("if1_c2", {mem_read, msel, loadir}, 3'b100);
        tick; chk("if2_c3", {mem_read, msel, loadir}, 3'b101);
        tick; chk("upc_c4", loadpc, 1);
        tick; chk("dec_c5", {write, loadpc, mem_read}, 3'b000);
        tick; chk("movi_c6", {write, vsel, nsel}, 5'b1_01_00);
        run = 0;
        tick; chk("done_c7_icount", icount, 0);
        tick; chk("movi_icount", icount, 1);
        repeat (5) tick;
        chk("idle_hold", {mem_read, icount}, {1'b0, 16'd1});
        // single-step ALU add, extra step pulse mid-instruction
        opcode = 3'b101; op = 2'b00; step = 1;
        tick; step = 0;
        chk("step_if1", mem_read, 1);
        repeat (3) tick;
        tick; chk("alu_geta", {loada, nsel}, 3'b1_00);
        tick; chk("alu_getb", {loadb, nsel}, 3'b1_10);
        step = 1;
        tick; step = 0;
        chk("alu_exe", {loadc, loads, asel, write}, 4'b1000);
        tick; chk("alu_wrc", {write, nsel, vsel}, 5'b1_01_11);
        tick; tick;
        chk("alu_icount", icount, 2);
        tick; chk("step_ignored", mem_read, 0);
        // CMP R0,R1
        opcode = 3'b101; op = 2'b01; step = 1;
        c_a = 0; c_b = 0; c_c = 0;
        for (int i = 0; i < 12; i++) begin
            tick; step = 0;
            c_a += loads; c_b += write; c_c += loadc;
        end
        chk("cmp_loads", c_a, 1);
        chk("cmp_nowrite", {c_b[7:0], c_c[7:0]}, 0);
        chk("cmp_icount", icount, 3);
        // STR R2,[R0,#0]
        opcode = 3'b100; op = 2'b00; step = 1;
        c_a = 0; c_b = 0; c_c = 0; c_d = 0;
        for (int i = 0; i < 12; i++) begin
            tick; step = 0;
            c_a += mem_write; c_b += mem_write & msel; c_c += write;
            if (loadb) c_d = nsel;
        end
        chk("str_memwrite", {c_a[7:0], c_b[7:0]}, {8'd1, 8'd1});
        chk("str_nowrite", c_c, 0);
        chk("str_nsel_b", c_d, 1);
        chk("str_icount", icount, 4);
        // undefined code acts as NOP
        opcode = 3'b000; op = 2'b11; step = 1;
        c_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick; step = 0;
            c_a += write + loada + loadb + loadc + loads + mem_write;
        end
        chk("nop_strobes", c_a, 0);
        chk("nop_icount", icount, 5);
        // HALT absorbs run/step, cleared by reset
        opcode = 3'b111; op = 2'b00; step = 1;
        tick; step = 0;
        repeat (5) tick;
        chk("halt_flag", halted, 1);
        run = 1; step = 1;
        repeat (6) tick;
        chk("halt_frozen", {halted, mem_read, icount}, {2'b10, 16'd5});
        run = 0; step = 0; reset = 0;
        tick; reset = 1;
        chk("halt_reset", {reset_pc, halted, icount}, {2'b10, 16'd0});
        // L=3 configuration: fetch latency and icount wrap
        opcode = 3'b110; op = 2'b10; reset = 0;
        tick; reset = 1; run = 1;
        c_a = 0; c_b = 0;
        for (int i = 1; i <= 5; i++) begin
            tick;
            c_a += mem_read3;
            if (loadir3) c_b = i;
        end
        chk("l3_fetch_mem_read", c_a, 4);
        chk("l3_loadir_cycle", c_b, 5);
        c_a = 0; c_b = icount3;
        for (int i = 0; i < 60 && c_a < 4; i++) begin
            tick;
            if (icount3 != c_b[1:0]) begin c_a++; c_b = icount3; end
        end
        run = 0;
        chk("wrap_count", c_a, 4);
        chk("wrap_icount", icount3, 0);
        // LDR R1,[R0,#2] with L=3
        opcode = 3'b011; op = 2'b00; step = 1;
        c_a = 0; c_b = 0; c_c = 0; c_d = 0; c_e = 0;
        for (int i = 0; i < 16; i++) begin
            tick; step = 0;
            c_a += msel3 & mem_read3; c_b += write3; c_c += bsel3 & loadc3;
            if (write3) c_d = {nsel3, vsel3, msel3};
            c_e += loada3;
        end
        chk("ldr_mrd_cycles", c_a, 4);
        chk("ldr_write", {c_b[7:0], c_c[7:0], c_e[7:0]}, {8'd1, 8'd1, 8'd1});
        chk("ldr_wrm", c_d, 5'b01_00_1);
        chk("ldr_icount", icount3, 1);
        // reset during LDR memory read abandons the write
        step = 1;
        tick; step = 0;
        repeat (9) tick;
        chk("mid_ldr_in_mrd", {msel3, mem_read3}, 2'b11);
        reset = 0;
        tick; reset = 1;
        c_a = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            c_a += write3;
        end
        chk("reset_ldr_nowrite", c_a, 0);
        chk("reset_ldr_icount", icount3, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
